// File: rtl/regfile_pkg.sv
// Shared constants and address-decode helper for the scoreboarded register file.
package regfile_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 3;
  localparam int MAX_AW = 8;
  localparam logic [MAX_AW-1:0] REG_ZERO = '0;

  // Bit r of the qualified onehot decode of address a.
  function automatic logic onehot_bit(input logic en, input logic [MAX_AW-1:0] a,
                                      input int unsigned r);
    return en && (a == r[MAX_AW-1:0]);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector with alloc-over-writeback priority and read stall detect.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_addr,
  input  logic                  we0,
  input  logic [AW-1:0]         waddr0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr1,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [(2**AW)-1:0]    busy,
  output logic                  stall
);
  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] set_v, clr_v;
  logic [NREAD-1:0] hit;

  for (genvar r = 0; r < DEPTH; r++) begin : g_dec
    assign set_v[r] = onehot_bit(alloc_en, MAX_AW'(alloc_addr), r) &&
                      !(ZERO_REG != 0 && r == int'(REG_ZERO));
    assign clr_v[r] = onehot_bit(we0, MAX_AW'(waddr0), r) ||
                      onehot_bit(we1, MAX_AW'(waddr1), r);
  end

  // Alloc wins over a same-edge writeback so back-to-back WAW keeps the reg busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= set_v | (busy & ~clr_v);
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_stall
    logic [AW-1:0] ra;
    logic          res;
    assign ra  = raddr[i*AW +: AW];
    assign res = (BYPASS != 0) && ((we0 && waddr0 == ra) || (we1 && waddr1 == ra));
    assign hit[i] = rd_en[i] && busy[ra] && !res;
  end

  assign stall = |hit;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with write-through bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [AW-1:0]         waddr0,
  input  logic [DW-1:0]         wdata0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr1,
  input  logic [DW-1:0]         wdata1,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*DW-1:0]   rdata,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_addr,
  output logic [(2**AW)-1:0]    busy,
  output logic                  stall
);
  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [DEPTH-1:0]         wsel0, wsel1;

  // Qualified write selects; also gated by reset so bypass reads 0 during reset.
  for (genvar r = 0; r < DEPTH; r++) begin : g_wdec
    logic keep;
    assign keep     = rst && !(ZERO_REG != 0 && r == int'(REG_ZERO));
    assign wsel0[r] = keep && onehot_bit(we0, MAX_AW'(waddr0), r);
    assign wsel1[r] = keep && onehot_bit(we1, MAX_AW'(waddr1), r);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem <= '0;
    else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wsel1[r])      mem[r] <= wdata1;
        else if (wsel0[r]) mem[r] <= wdata0;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    assign ra = raddr[i*AW +: AW];
    always_comb begin
      rd = mem[ra];
      if (BYPASS != 0) begin
        if (wsel0[ra]) rd = wdata0;
        if (wsel1[ra]) rd = wdata1;
      end
      if (!rst) rd = '0;
    end
    assign rdata[i*DW +: DW] = rd;
  end

  regfile_scoreboard #(
    .AW(AW), .NREAD(NREAD), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .we0(we0), .waddr0(waddr0), .we1(we1), .waddr1(waddr1),
    .rd_en(rd_en), .raddr(raddr),
    .busy(busy), .stall(stall)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Drives two configurations (bypass / zero-reg+no-bypass) against a behavioural model.
module tb_regfile_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we0, we1, alloc_en;
  logic [2:0]  waddr0, waddr1, alloc_addr;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  rd_en;
  logic [5:0]  raddr;
  wire  [63:0] rdata_a, rdata_b;
  wire  [7:0]  busy_a, busy_b;
  wire         stall_a, stall_b;

  int checks = 0, failures = 0;
  logic [31:0] mem_m [2][8];
  bit          busy_m[2][8];

  regfile_sb #(.ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata_a), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy(busy_a), .stall(stall_a));

  regfile_sb #(.ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata_b), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy(busy_b), .stall(stall_b));

  // d=0: plain regs with bypass; d=1: reg 0 hardwired, no bypass.
  function automatic logic [31:0] exp_rd(int d, logic [2:0] a);
    if (!rst) return 32'h0;
    if (d == 1 && a == 3'd0) return 32'h0;
    if (d == 0) begin
      if (we1 && waddr1 == a) return wdata1;
      if (we0 && waddr0 == a) return wdata0;
    end
    return mem_m[d][a];
  endfunction

  function automatic logic [7:0] exp_busy(int d);
    logic [7:0] v = '0;
    for (int r = 0; r < 8; r++) v[r] = busy_m[d][r];
    return v;
  endfunction

  function automatic logic exp_stall(int d);
    for (int i = 0; i < 2; i++) begin
      logic [2:0] a = raddr[i*3 +: 3];
      bit wr = (we0 && waddr0 == a) || (we1 && waddr1 == a);
      if (rd_en[i] && busy_m[d][a] && !(d == 0 && wr)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk($sformatf("%s a.rd0", tag), 64'(rdata_a[31:0]),  64'(exp_rd(0, raddr[2:0])));
    chk($sformatf("%s a.rd1", tag), 64'(rdata_a[63:32]), 64'(exp_rd(0, raddr[5:3])));
    chk($sformatf("%s b.rd0", tag), 64'(rdata_b[31:0]),  64'(exp_rd(1, raddr[2:0])));
    chk($sformatf("%s b.rd1", tag), 64'(rdata_b[63:32]), 64'(exp_rd(1, raddr[5:3])));
    chk($sformatf("%s a.busy", tag), 64'(busy_a), 64'(exp_busy(0)));
    chk($sformatf("%s b.busy", tag), 64'(busy_b), 64'(exp_busy(1)));
    chk($sformatf("%s a.stall", tag), 64'(stall_a), 64'(exp_stall(0)));
    chk($sformatf("%s b.stall", tag), 64'(stall_b), 64'(exp_stall(1)));
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (we0 && !(d == 1 && waddr0 == 3'd0)) mem_m[d][waddr0] = wdata0;
      if (we1 && !(d == 1 && waddr1 == 3'd0)) mem_m[d][waddr1] = wdata1;
      if (we0) busy_m[d][waddr0] = 1'b0;
      if (we1) busy_m[d][waddr1] = 1'b0;
      if (alloc_en && !(d == 1 && alloc_addr == 3'd0)) busy_m[d][alloc_addr] = 1'b1;
    end
  endtask

  // Inputs are set at the falling edge; check 1ns later, then advance one clock.
  task automatic cycle(string tag);
    #1;
    if (!rst)
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 8; r++) begin mem_m[d][r] = '0; busy_m[d][r] = 1'b0; end
    check_all(tag);
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; alloc_en = 0; rd_en = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; alloc_addr = 0;
  endtask

  initial begin
    rst = 1'b0; idle(); raddr = {3'd3, 3'd0};
    cycle("reset0"); cycle("reset1");
    rst = 1'b1;
    we0 = 1; waddr0 = 3'd0; wdata0 = 32'hABCD1234; raddr = {3'd6, 3'd0};
    cycle("wr0_bypass");
    idle(); cycle("wr0_after");
    we0 = 1; waddr0 = 3'd6; wdata0 = 32'h0BAD_F00D; raddr = {3'd0, 3'd6};
    cycle("wr6_same");
    idle(); cycle("wr6_after");
    we0 = 1; we1 = 1; waddr0 = 3'd5; waddr1 = 3'd5;
    wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222; raddr = {3'd0, 3'd5};
    cycle("collide_same");
    idle(); cycle("collide_after");
    alloc_en = 1; alloc_addr = 3'd4; cycle("alloc4");
    idle(); rd_en = 2'b01; raddr = {3'd1, 3'd4}; cycle("stall4");
    we1 = 1; waddr1 = 3'd4; wdata1 = 32'h55; cycle("wb4");
    idle(); rd_en = 2'b01; cycle("wb4_after");
    alloc_en = 1; alloc_addr = 3'd2; cycle("alloc2");
    alloc_en = 1; alloc_addr = 3'd2; we0 = 1; waddr0 = 3'd2; wdata0 = 32'h7777_0002;
    raddr = {3'd2, 3'd2}; cycle("waw2");
    idle(); rd_en = 2'b10; raddr = {3'd2, 3'd0}; cycle("waw2_after");
    we0 = 1; waddr0 = 3'd0; wdata0 = 32'hFFFF_FFFF; alloc_en = 1; alloc_addr = 3'd0;
    cycle("zero_wr");
    idle(); rd_en = 2'b11; raddr = {3'd0, 3'd0}; cycle("zero_rd");
    alloc_en = 1; alloc_addr = 3'd3; cycle("alloc3");
    idle(); rd_en = 2'b01; raddr = {3'd2, 3'd3}; cycle("stall3");
    rst = 1'b0; cycle("rst_mid");
    rst = 1'b1; idle(); cycle("post_rst");

    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 60) != 0);
      we0        = $urandom_range(0, 1) == 1;
      we1        = $urandom_range(0, 2) == 0;
      waddr0     = 3'($urandom);
      waddr1     = 3'($urandom);
      wdata0     = $urandom;
      wdata1     = $urandom;
      alloc_en   = $urandom_range(0, 1) == 1;
      alloc_addr = 3'($urandom);
      rd_en      = 2'($urandom);
      raddr      = 6'($urandom);
      cycle($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
